// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI pins plus transmit/receive byte streams of the SPI target.
// Revision : 1.0
// ============================================================================
interface spi_slave_if;
    logic [1:0] cp_mode_i;
    logic       msb_first_i;
    logic       spi_clk_i;
    logic       spi_ss_i;
    logic       spi_dq0_i;
    logic       spi_dq1_o;
    logic       spi_dq1_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;
    logic       underrun_o;

    modport slave (
        input  cp_mode_i, msb_first_i, spi_clk_i, spi_ss_i, spi_dq0_i,
        input  tx_data_i, tx_valid_i,
        output spi_dq1_o, spi_dq1_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        output busy_o, underrun_o
    );

    modport master (
        output cp_mode_i, msb_first_i, spi_clk_i, spi_ss_i, spi_dq0_i,
        output tx_data_i, tx_valid_i,
        input  spi_dq1_o, spi_dq1_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        input  busy_o, underrun_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Oversampled SPI target, all CPOL/CPHA modes, byte-stream rx/tx.
// Revision : 1.0
// ============================================================================
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_DATA   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    spi_slave_if.slave bus
);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic       sclk_dly_q, sclk_dly_d, ss_dly_q, ss_dly_d;
    logic [0:0] state_q, state_d;
    logic       cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic       hold_full_q, hold_full_d, underrun_q, underrun_d, dq1_q, dq1_d;

    logic       w_sclk_s, w_ss_s, w_mosi_s;
    logic       w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_ss_fall;
    logic       w_sample_edge, w_shift_edge, w_push, w_fetch;
    logic [2:0] w_rx_idx;

    assign w_sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign w_ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign w_mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise   = w_sclk_s & ~sclk_dly_q;
    assign w_sclk_fall   = ~w_sclk_s & sclk_dly_q;
    // Leading edge moves away from the idle level CPOL.
    assign w_lead        = cpol_q ? w_sclk_fall : w_sclk_rise;
    assign w_trail       = cpol_q ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = cpha_q ? w_trail : w_lead;
    assign w_shift_edge  = cpha_q ? w_lead : w_trail;
    // Falling edge (not level) so the cleared synchronizer cannot start a frame out of reset.
    assign w_ss_fall     = ~w_ss_s & ss_dly_q;
    assign w_push        = bus.tx_valid_i & ~hold_full_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk_i};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_dq0_i};
        sclk_dly_d  = w_sclk_s;
        ss_dly_d    = w_ss_s;
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        msb_d       = msb_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        w_fetch     = 1'b0;
        w_rx_idx    = msb_q ? (3'd7 - bit_cnt_q) : bit_cnt_q;

        case (state_q)
            c_IDLE: begin
                if (w_ss_fall) begin
                    state_d    = c_ACTIVE;
                    cpol_d     = bus.cp_mode_i[1];
                    cpha_d     = bus.cp_mode_i[0];
                    msb_d      = bus.msb_first_i;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    w_fetch    = ~bus.cp_mode_i[0];
                end
            end
            default: begin
                if (w_ss_s) begin
                    state_d = c_IDLE;
                end else if (w_sample_edge) begin
                    rx_shift_d[w_rx_idx] = w_mosi_s;
                    bit_cnt_d            = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                    end
                end else if (w_shift_edge) begin
                    // bit_cnt==0 on a shift edge marks a byte boundary in both phases.
                    if (bit_cnt_q == 3'd0) begin
                        w_fetch = 1'b1;
                    end else begin
                        tx_shift_d = msb_q ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
        endcase

        if (w_fetch) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_DATA;
                underrun_d = 1'b1;
            end
        end
        if (w_push) begin
            hold_d      = bus.tx_data_i;
            hold_full_d = 1'b1;
        end
        dq1_d = msb_q ? tx_shift_q[7] : tx_shift_q[0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b0;
            state_q     <= c_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            msb_q       <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            dq1_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_dly_q    <= ss_dly_d;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            msb_q       <= msb_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            dq1_q       <= dq1_d;
        end
    end

    assign bus.spi_dq1_o    = dq1_q;
    assign bus.spi_dq1_oe_o = (state_q == c_ACTIVE);
    assign bus.busy_o       = (state_q == c_ACTIVE);
    assign bus.tx_ready_o   = ~hold_full_q;
    assign bus.rx_data_o    = rx_data_q;
    assign bus.rx_valid_o   = rx_valid_q;
    assign bus.underrun_o   = underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave: vector table plus corner cases.
// Revision : 1.0
// ============================================================================
module tb_spi_slave;
    localparam int SYNC = 2;
    localparam int H    = 8;

    logic clk;
    logic rst;
    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(SYNC), .IDLE_DATA(8'hFF)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int unr_cnt = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];

    typedef struct {
        logic [1:0] mode;
        logic       msb;
        logic       push;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] miso;
        logic [7:0] rx;
        int         unr;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts underrun pulses, pops the rx scoreboard on every rx_valid_o
    always @(negedge clk) begin
        if (bus.underrun_o === 1'b1) unr_cnt++;
        if (bus.rx_valid_o === 1'b1) begin
            if (rx_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected: got rx_valid_o with data %0h, expected none", bus.rx_data_o);
            end else begin
                check("rx_data", bus.rx_data_o, rx_exp.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int k;
        k = 0;
        while (bus.tx_ready_o !== 1'b1 && k < 200) begin
            wait_cycles(1);
            k++;
        end
        if (k == 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: tx_ready_o is %b, expected 1", bus.tx_ready_o);
        end else begin
            bus.tx_data_i  = d;
            bus.tx_valid_i = 1'b1;
            wait_cycles(1);
            bus.tx_valid_i = 1'b0;
        end
    endtask

    task automatic set_mode(input logic [1:0] m, input logic msb);
        bus.cp_mode_i   = m;
        bus.msb_first_i = msb;
        bus.spi_clk_i   = m[1];
        wait_cycles(SYNC + 3);
    endtask

    task automatic frame_start();
        wait_cycles(1);
        bus.spi_ss_i = 1'b0;
    endtask

    task automatic frame_end();
        wait_cycles(H);
        bus.spi_ss_i = 1'b1;
        wait_cycles(H);
    endtask

    // Master: MOSI driven and MISO captured in wire order, first bit into bit 7
    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        logic cpol, cpha;
        cpol = bus.cp_mode_i[1];
        cpha = bus.cp_mode_i[0];
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) bus.spi_dq0_i = mosi[7-i];
            wait_cycles(H);
            if (!cpha) miso[7-i] = bus.spi_dq1_o;
            bus.spi_clk_i = ~cpol;
            if (cpha) bus.spi_dq0_i = mosi[7-i];
            wait_cycles(H);
            if (cpha) miso[7-i] = bus.spi_dq1_o;
            bus.spi_clk_i = cpol;
        end
    endtask

    task automatic spi_byte(input logic [7:0] mosi);
        logic [7:0] got;
        spi_bits(mosi, 8, got);
        if (miso_exp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL miso_unexpected: got byte %0h, expected none", got);
        end else begin
            check("miso_byte", got, miso_exp.pop_front());
        end
    endtask

    initial begin
        logic [7:0] dummy;
        int         u0;
        logic [1:0] two_modes[2];
        int         two_unr[2];

        rst             = 1'b1;
        bus.spi_ss_i    = 1'b1;
        bus.spi_clk_i   = 1'b0;
        bus.spi_dq0_i   = 1'b0;
        bus.tx_data_i   = 8'h00;
        bus.tx_valid_i  = 1'b0;
        bus.cp_mode_i   = 2'b00;
        bus.msb_first_i = 1'b1;

        //                 mode   msb   push  tx     mosi   miso   rx     unr
        vecs[0] = '{2'b00, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
        vecs[1] = '{2'b11, 1'b0, 1'b1, 8'h01, 8'h80, 8'h80, 8'h01, 0};
        vecs[2] = '{2'b01, 1'b1, 1'b1, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 0};
        vecs[3] = '{2'b10, 1'b0, 1'b1, 8'h0F, 8'h6B, 8'hF0, 8'hD6, 1};
        vecs[4] = '{2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 2};
        vecs[5] = '{2'b11, 1'b1, 1'b1, 8'h7E, 8'hE7, 8'h7E, 8'hE7, 0};

        wait_cycles(2);
        check("rst_rx_data",  bus.rx_data_o,    8'h00);
        check("rst_rx_valid", bus.rx_valid_o,   1'b0);
        check("rst_tx_ready", bus.tx_ready_o,   1'b1);
        check("rst_dq1",      bus.spi_dq1_o,    1'b0);
        check("rst_dq1_oe",   bus.spi_dq1_oe_o, 1'b0);
        check("rst_busy",     bus.busy_o,       1'b0);
        check("rst_underrun", bus.underrun_o,   1'b0);
        rst = 1'b0;
        wait_cycles(SYNC + 4);
        check("idle_after_reset", bus.busy_o, 1'b0);

        // Single-byte frames across modes and bit orders
        for (int v = 0; v < 6; v++) begin
            set_mode(vecs[v].mode, vecs[v].msb);
            if (vecs[v].push) push_tx(vecs[v].tx);
            u0 = unr_cnt;
            rx_exp.push_back(vecs[v].rx);
            miso_exp.push_back(vecs[v].miso);
            frame_start();
            spi_byte(vecs[v].mosi);
            frame_end();
            check("vec_underruns", unr_cnt - u0, vecs[v].unr);
            check("vec_tx_ready", bus.tx_ready_o, 1'b1);
            check("vec_busy_end", bus.busy_o, 1'b0);
        end

        // Two-byte frames, second byte pushed once the holding register frees
        two_modes[0] = 2'b01; two_unr[0] = 0;
        two_modes[1] = 2'b10; two_unr[1] = 1;
        for (int t = 0; t < 2; t++) begin
            set_mode(two_modes[t], 1'b1);
            push_tx(8'h12);
            u0 = unr_cnt;
            miso_exp.push_back(8'h12); miso_exp.push_back(8'h34);
            rx_exp.push_back(8'hF0);   rx_exp.push_back(8'h0F);
            frame_start();
            fork
                begin
                    spi_byte(8'hF0);
                    spi_byte(8'h0F);
                end
                push_tx(8'h34);
            join
            frame_end();
            check("two_byte_underruns", unr_cnt - u0, two_unr[t]);
        end

        // Underrun: two bytes, nothing pushed
        set_mode(2'b01, 1'b1);
        u0 = unr_cnt;
        miso_exp.push_back(8'hFF); miso_exp.push_back(8'hFF);
        rx_exp.push_back(8'h11);   rx_exp.push_back(8'h22);
        frame_start();
        spi_byte(8'h11);
        spi_byte(8'h22);
        frame_end();
        check("underrun_count", unr_cnt - u0, 2);

        // Push lands in the same cycle as the frame-start fetch
        set_mode(2'b00, 1'b1);
        u0 = unr_cnt;
        miso_exp.push_back(8'hFF); miso_exp.push_back(8'h9C);
        rx_exp.push_back(8'h33);   rx_exp.push_back(8'hCC);
        frame_start();
        wait_cycles(SYNC);
        bus.tx_data_i  = 8'h9C;
        bus.tx_valid_i = 1'b1;
        wait_cycles(1);
        bus.tx_valid_i = 1'b0;
        check("race_underrun_pulse", bus.underrun_o, 1'b1);
        check("race_tx_ready", bus.tx_ready_o, 1'b0);
        spi_byte(8'h33);
        spi_byte(8'hCC);
        frame_end();
        check("race_underruns", unr_cnt - u0, 2);

        // Abort after 5 bits, then a clean frame
        set_mode(2'b00, 1'b1);
        push_tx(8'h55);
        frame_start();
        spi_bits(8'hA0, 5, dummy);
        wait_cycles(H / 2);
        check("abort_busy_before", bus.busy_o, 1'b1);
        bus.spi_ss_i = 1'b1;
        wait_cycles(SYNC + 1);
        check("abort_busy", bus.busy_o, 1'b0);
        check("abort_oe", bus.spi_dq1_oe_o, 1'b0);
        wait_cycles(H);
        push_tx(8'hAA);
        miso_exp.push_back(8'hAA);
        rx_exp.push_back(8'h96);
        frame_start();
        spi_byte(8'h96);
        frame_end();

        // Asynchronous reset in the middle of a byte
        set_mode(2'b00, 1'b1);
        push_tx(8'hFF);
        frame_start();
        spi_bits(8'h00, 3, dummy);
        push_tx(8'h42);
        check("pre_rst_ready", bus.tx_ready_o, 1'b0);
        check("pre_rst_busy", bus.busy_o, 1'b1);
        check("pre_rst_dq1", bus.spi_dq1_o, 1'b1);
        @(negedge clk);
        #2;
        rst          = 1'b1;
        bus.spi_ss_i = 1'b1;
        #1;
        check("mid_rst_rx_data",  bus.rx_data_o,    8'h00);
        check("mid_rst_rx_valid", bus.rx_valid_o,   1'b0);
        check("mid_rst_tx_ready", bus.tx_ready_o,   1'b1);
        check("mid_rst_dq1",      bus.spi_dq1_o,    1'b0);
        check("mid_rst_dq1_oe",   bus.spi_dq1_oe_o, 1'b0);
        check("mid_rst_busy",     bus.busy_o,       1'b0);
        check("mid_rst_underrun", bus.underrun_o,   1'b0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(SYNC + 3);
        check("post_rst_idle", bus.busy_o, 1'b0);
        push_tx(8'h3E);
        u0 = unr_cnt;
        miso_exp.push_back(8'h3E);
        rx_exp.push_back(8'h71);
        frame_start();
        spi_byte(8'h71);
        frame_end();
        check("post_rst_underruns", unr_cnt - u0, 1);

        wait_cycles(10);
        check("rx_queue_drained", rx_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
